// File: rtl/fp_operand_unpacker.sv
// Splits an IEEE-754 operand pair into sign/exponent/significand, classifies each, orders by magnitude.
// Latency 2 cycles (unpack register, order register); one pair per cycle; stalls hold outputs, in_ready follows out_ready.
module fp_operand_unpacker #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 big_sign,
    output logic                 small_sign,
    output logic [EXP_W-1:0]     big_exp,
    output logic [EXP_W-1:0]     small_exp,
    output logic [MAN_W:0]       big_sig,
    output logic [MAN_W:0]       small_sig,
    output logic [EXP_W-1:0]     exp_diff,
    output logic                 swapped,
    output logic [3:0]           a_class,
    output logic [3:0]           b_class
);
    localparam int W = 1 + EXP_W + MAN_W;
    localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};

    // class bits: {nan, inf, subnormal, zero}
    function automatic logic [3:0] classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
        logic e_zero;
        logic e_ones;
        logic f_zero;
        e_zero = (e == '0);
        e_ones = (e == '1);
        f_zero = (f == '0);
        return {e_ones && !f_zero, e_ones && f_zero, e_zero && !f_zero, e_zero && f_zero};
    endfunction

    logic             s1_vld;
    logic             s1_a_sign, s1_b_sign;
    logic [EXP_W-1:0] s1_a_exp, s1_b_exp;
    logic [MAN_W:0]   s1_a_sig, s1_b_sig;
    logic [3:0]       s1_a_class, s1_b_class;
    logic [W-2:0]     s1_a_mag, s1_b_mag;

    logic s2_adv;
    logic s1_adv;
    logic b_gt;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_vld || s2_adv;
    assign in_ready = !reset && s1_adv;

    // Ordering uses the raw magnitude bits so NaN/Inf need no special handling.
    assign b_gt = (s1_b_mag > s1_a_mag);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld     <= 1'b0;
            s1_a_sign  <= 1'b0;
            s1_b_sign  <= 1'b0;
            s1_a_exp   <= '0;
            s1_b_exp   <= '0;
            s1_a_sig   <= '0;
            s1_b_sig   <= '0;
            s1_a_class <= '0;
            s1_b_class <= '0;
            s1_a_mag   <= '0;
            s1_b_mag   <= '0;
        end else if (s1_adv) begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_a_sign  <= a[W-1];
                s1_b_sign  <= b[W-1];
                s1_a_exp   <= (a[W-2:MAN_W] == '0) ? EXP_ONE : a[W-2:MAN_W];
                s1_b_exp   <= (b[W-2:MAN_W] == '0) ? EXP_ONE : b[W-2:MAN_W];
                s1_a_sig   <= {a[W-2:MAN_W] != '0, a[MAN_W-1:0]};
                s1_b_sig   <= {b[W-2:MAN_W] != '0, b[MAN_W-1:0]};
                s1_a_class <= classify(a[W-2:MAN_W], a[MAN_W-1:0]);
                s1_b_class <= classify(b[W-2:MAN_W], b[MAN_W-1:0]);
                s1_a_mag   <= a[W-2:0];
                s1_b_mag   <= b[W-2:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            big_sign   <= 1'b0;
            small_sign <= 1'b0;
            big_exp    <= '0;
            small_exp  <= '0;
            big_sig    <= '0;
            small_sig  <= '0;
            exp_diff   <= '0;
            swapped    <= 1'b0;
            a_class    <= '0;
            b_class    <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_vld;
            if (s1_vld) begin
                swapped    <= b_gt;
                big_sign   <= b_gt ? s1_b_sign : s1_a_sign;
                small_sign <= b_gt ? s1_a_sign : s1_b_sign;
                big_exp    <= b_gt ? s1_b_exp  : s1_a_exp;
                small_exp  <= b_gt ? s1_a_exp  : s1_b_exp;
                big_sig    <= b_gt ? s1_b_sig  : s1_a_sig;
                small_sig  <= b_gt ? s1_a_sig  : s1_b_sig;
                // Larger magnitude never has a smaller effective exponent.
                exp_diff   <= b_gt ? (s1_b_exp - s1_a_exp) : (s1_a_exp - s1_b_exp);
                a_class    <= s1_a_class;
                b_class    <= s1_b_class;
            end
        end
    end
endmodule

// File: tb/tb_fp_operand_unpacker.sv
// Randomized and directed checks of fp_operand_unpacker against a magnitude-ordering reference model.
module tb_fp_operand_unpacker;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b;
    logic        big_sign, small_sign, swapped;
    logic [7:0]  big_exp, small_exp, exp_diff;
    logic [23:0] big_sig, small_sig;
    logic [3:0]  a_class, b_class;

    logic        in_valid_s, in_ready_s, out_valid_s, out_ready_s;
    logic [15:0] a_s, b_s;
    logic        big_sign_s, small_sign_s, swapped_s;
    logic [4:0]  big_exp_s, small_exp_s, exp_diff_s;
    logic [10:0] big_sig_s, small_sig_s;
    logic [3:0]  a_class_s, b_class_s;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fp_operand_unpacker #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .big_sign(big_sign), .small_sign(small_sign),
        .big_exp(big_exp), .small_exp(small_exp), .big_sig(big_sig), .small_sig(small_sig),
        .exp_diff(exp_diff), .swapped(swapped), .a_class(a_class), .b_class(b_class)
    );

    fp_operand_unpacker #(.EXP_W(5), .MAN_W(10)) dut_half (
        .clk(clk), .reset(reset), .in_valid(in_valid_s), .in_ready(in_ready_s), .a(a_s), .b(b_s),
        .out_valid(out_valid_s), .out_ready(out_ready_s), .big_sign(big_sign_s), .small_sign(small_sign_s),
        .big_exp(big_exp_s), .small_exp(small_exp_s), .big_sig(big_sig_s), .small_sig(small_sig_s),
        .exp_diff(exp_diff_s), .swapped(swapped_s), .a_class(a_class_s), .b_class(b_class_s)
    );

    logic [82:0] obs;
    assign obs = {big_sign, small_sign, big_exp, small_exp, big_sig, small_sig, exp_diff, swapped, a_class, b_class};
    logic [81:0] obs_spec;
    assign obs_spec = {swapped, big_sign, big_exp, big_sig, small_exp, small_sig, exp_diff, a_class, b_class};

    function automatic logic [3:0] cls(input logic [31:0] v);
        int e;
        int f;
        e = int'(v[30:23]);
        f = int'(v[22:0]);
        if (e == 255) return (f != 0) ? 4'b1000 : 4'b0100;
        if (e == 0)   return (f != 0) ? 4'b0010 : 4'b0001;
        return 4'b0000;
    endfunction

    function automatic logic [82:0] model(input logic [31:0] x, input logic [31:0] y);
        longint unsigned xm, ym;
        bit sw;
        logic [31:0] bg, sm;
        int bexp, sexp;
        logic [23:0] bsig, ssig;
        xm = longint'(x[30:0]);
        ym = longint'(y[30:0]);
        sw = (ym > xm);
        bg = sw ? y : x;
        sm = sw ? x : y;
        bexp = (bg[30:23] == 0) ? 1 : int'(bg[30:23]);
        sexp = (sm[30:23] == 0) ? 1 : int'(sm[30:23]);
        bsig = {bg[30:23] != 0, bg[22:0]};
        ssig = {sm[30:23] != 0, sm[22:0]};
        return {bg[31], sm[31], 8'(bexp), 8'(sexp), bsig, ssig, 8'(bexp - sexp), sw, cls(x), cls(y)};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 6))
            0: v[30:23] = 8'h00;
            1: v[30:23] = 8'hFF;
            2: v[22:0] = '0;
            3: v[30:0] = '0;
            4: begin v[30:23] = 8'hFF; v[22:0] = '0; end
            5: v[30:23] = 8'(8'h7C + $urandom_range(0, 6));
            default: ;
        endcase
        return v;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        in_valid_s = 1'b0; out_ready_s = 1'b1; a_s = '0; b_s = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++;
        if (obs !== '0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", obs); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL post_reset_idle: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_vectors();
        logic [31:0] va[3];
        logic [31:0] vb[3];
        logic [81:0] spec[3];
        va[0] = 32'h3F800000; vb[0] = 32'h40000000;
        va[1] = 32'h00000001; vb[1] = 32'h00000000;
        va[2] = 32'h7F800000; vb[2] = 32'hFFC00000;
        spec[0] = {1'b1, 1'b0, 8'h80, 24'h800000, 8'h7F, 24'h800000, 8'h01, 4'h0, 4'h0};
        spec[1] = {1'b0, 1'b0, 8'h01, 24'h000001, 8'h01, 24'h000000, 8'h00, 4'h2, 4'h1};
        spec[2] = {1'b1, 1'b1, 8'hFF, 24'hC00000, 8'hFF, 24'h800000, 8'h00, 4'h4, 4'h8};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; out_ready = 1'b1; a = va[i]; b = vb[i];
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0) begin n_bad++; $display("FAIL vec%0d_early_valid: got %b want 0", i, out_valid); end
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1) begin n_bad++; $display("FAIL vec%0d_latency: got %b want 1", i, out_valid); end
            n_cmp++;
            if (obs_spec !== spec[i]) begin n_bad++; $display("FAIL vec%0d_fields: got %h want %h", i, obs_spec, spec[i]); end
            n_cmp++;
            if (obs !== model(va[i], vb[i])) begin n_bad++; $display("FAIL vec%0d_model: got %h want %h", i, obs, model(va[i], vb[i])); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_half_precision();
        @(posedge clk); #1;
        in_valid_s = 1'b1; a_s = 16'h3C00; b_s = 16'h3C00;
        @(posedge clk); #1;
        in_valid_s = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (out_valid_s !== 1'b1) begin n_bad++; $display("FAIL half_valid: got %b want 1", out_valid_s); end
        n_cmp++;
        if ({swapped_s, big_exp_s, small_exp_s, big_sig_s, small_sig_s, exp_diff_s, a_class_s, b_class_s}
            !== {1'b0, 5'h0F, 5'h0F, 11'h400, 11'h400, 5'h00, 4'h0, 4'h0}) begin
            n_bad++;
            $display("FAIL half_tie: got sw=%b be=%h se=%h bs=%h ss=%h ed=%h want 0/0f/0f/400/400/00",
                     swapped_s, big_exp_s, small_exp_s, big_sig_s, small_sig_s, exp_diff_s);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        logic [31:0] pa[3];
        logic [31:0] pb[3];
        logic [82:0] held;
        int idx;
        int k;
        bit took;
        pa[0] = 32'h40490FDB; pb[0] = 32'hC0000000;
        pa[1] = 32'h00400000; pb[1] = 32'h3F000000;
        pa[2] = 32'hC2C80000; pb[2] = 32'h42C80001;
        idx = 0; k = 0;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; a = pa[0]; b = pb[0];
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            took = in_valid && in_ready;
            @(posedge clk); #1;
            if (took) begin
                idx++;
                if (idx < 3) begin a = pa[idx]; b = pb[idx]; end
            end
        end
        @(negedge clk);
        n_cmp++;
        if (idx !== 2 || in_ready !== 1'b0) begin
            n_bad++; $display("FAIL stall_full: accepted %0d in_ready=%b want 2/0", idx, in_ready);
        end
        n_cmp++;
        if (out_valid !== 1'b1 || obs !== model(pa[0], pb[0])) begin
            n_bad++; $display("FAIL stall_head: got v=%b %h want 1 %h", out_valid, obs, model(pa[0], pb[0]));
        end
        held = obs;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || obs !== held) begin
                n_bad++; $display("FAIL stall_hold%0d: got v=%b %h want 1 %h", c, out_valid, obs, held);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int c = 0; c < 10 && k < 3; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                n_cmp++;
                if (obs !== model(pa[k], pb[k])) begin
                    n_bad++; $display("FAIL drain%0d: got %h want %h", k, obs, model(pa[k], pb[k]));
                end
                k++;
            end
            took = in_valid && in_ready;
            @(posedge clk); #1;
            if (took) begin idx++; in_valid = 1'b0; end
        end
        n_cmp++;
        if (k !== 3 || idx !== 3) begin n_bad++; $display("FAIL drain_count: emitted %0d accepted %0d want 3/3", k, idx); end
    endtask

    task automatic test_reset_flush();
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; a = 32'h41200000; b = 32'h3DCCCCCD;
        @(posedge clk); #1;
        a = 32'hBF800000; b = 32'h7F7FFFFF;
        @(posedge clk); #1;
        a = 32'h12345678; b = 32'h23456789;
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || obs !== '0) begin
            n_bad++; $display("FAIL flush_outputs: got v=%b %h want 0 0", out_valid, obs);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_ready: got %b want 1", in_ready); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_ghost%0d: got out_valid %b want 0", c, out_valid); end
        end
    endtask

    task automatic test_random();
        logic [31:0] qa[$];
        logic [31:0] qb[$];
        logic [31:0] xa, xb;
        logic [82:0] prev;
        bit prev_stall;
        prev_stall = 0;
        prev = '0;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            a = rand_op();
            b = ($urandom_range(0, 7) == 0) ? {~a[31], a[30:0]} : rand_op();
            @(negedge clk);
            n_cmp++;
            if (in_ready !== (qa.size() < 2 || out_ready)) begin
                n_bad++; $display("FAIL rnd_in_ready c%0d: got %b held %0d", c, in_ready, qa.size());
            end
            if (prev_stall) begin
                n_cmp++;
                if (out_valid !== 1'b1 || obs !== prev) begin
                    n_bad++; $display("FAIL rnd_hold c%0d: got v=%b %h want 1 %h", c, out_valid, obs, prev);
                end
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (qa.size() == 0) begin
                    n_bad++; $display("FAIL rnd_spurious c%0d: got %h want nothing", c, obs);
                end else begin
                    xa = qa.pop_front();
                    xb = qb.pop_front();
                    if (obs !== model(xa, xb)) begin
                        n_bad++; $display("FAIL rnd_data c%0d a=%h b=%h: got %h want %h", c, xa, xb, obs, model(xa, xb));
                    end
                end
            end
            if (in_valid && in_ready) begin qa.push_back(a); qb.push_back(b); end
            prev_stall = out_valid && !out_ready;
            prev = obs;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) begin
                n_cmp++;
                if (qa.size() == 0) begin
                    n_bad++; $display("FAIL rnd_drain_spurious: got %h want nothing", obs);
                end else begin
                    xa = qa.pop_front();
                    xb = qb.pop_front();
                    if (obs !== model(xa, xb)) begin
                        n_bad++; $display("FAIL rnd_drain a=%h b=%h: got %h want %h", xa, xb, obs, model(xa, xb));
                    end
                end
            end
        end
        n_cmp++;
        if (qa.size() != 0) begin n_bad++; $display("FAIL rnd_lost: got %0d undelivered want 0", qa.size()); end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_half_precision();
        test_stall();
        test_reset_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
